// File: rtl/force_override_stage.sv
// Registered override stage: passes a baseline value through one register and lets
// commands force a fixed value onto it or release it back to the baseline after a delay.
module force_override_stage #(
    parameter int WIDTH = 8,
    parameter int DLY_W = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] base_i,
    input  logic             cmd_valid_i,
    output logic             cmd_ready_o,
    input  logic             cmd_op_i,
    input  logic [WIDTH-1:0] cmd_value_i,
    input  logic [DLY_W-1:0] cmd_delay_i,
    output logic [WIDTH-1:0] data_o,
    output logic             forced_o,
    output logic             done_o,
    output logic             err_o,
    output logic [CNT_W-1:0] forced_cycles_o
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WAIT   = 2'd1,
        ST_FORCED = 2'd2,
        ST_RWAIT  = 2'd3
    } state_t;

    localparam logic [DLY_W-1:0] DLY_ONE = DLY_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    state_t           state_r, state_s;
    logic [DLY_W-1:0] cnt_r, cnt_s;
    logic [WIDTH-1:0] val_r, val_s;
    logic [WIDTH-1:0] data_r, data_s;
    logic             forced_r, forced_s;
    logic             done_r, done_s;
    logic             err_r, err_s;
    logic [CNT_W-1:0] fcnt_r, fcnt_s;
    logic             ready_s;
    logic             accept_s;
    logic             dly_zero_s;

    // Handshake: commands only accepted in the two stable states and never in reset.
    always_comb begin
        ready_s    = rst_n && ((state_r == ST_IDLE) || (state_r == ST_FORCED));
        accept_s   = cmd_valid_i && ready_s;
        dly_zero_s = (cmd_delay_i == {DLY_W{1'b0}});
    end

    // Next-state and output-value logic for the override sequence.
    always_comb begin
        state_s  = state_r;
        cnt_s    = cnt_r;
        val_s    = val_r;
        data_s   = data_r;
        forced_s = forced_r;
        done_s   = 1'b0;
        err_s    = err_r;
        case (state_r)
            ST_IDLE: begin
                data_s = base_i;
                if (accept_s && cmd_op_i) begin
                    val_s = cmd_value_i;
                    if (dly_zero_s) begin
                        data_s   = cmd_value_i;
                        forced_s = 1'b1;
                        done_s   = 1'b1;
                        state_s  = ST_FORCED;
                    end else begin
                        cnt_s   = cmd_delay_i - DLY_ONE;
                        state_s = ST_WAIT;
                    end
                end else if (accept_s) begin
                    // Releasing something that is not forced is a protocol error.
                    err_s = 1'b1;
                end else begin
                    err_s = err_r;
                end
            end
            ST_WAIT: begin
                // A pending re-force keeps the old forced value; a first force still tracks base.
                if (forced_r) begin
                    data_s = data_r;
                end else begin
                    data_s = base_i;
                end
                if (cnt_r == {DLY_W{1'b0}}) begin
                    data_s   = val_r;
                    forced_s = 1'b1;
                    done_s   = 1'b1;
                    state_s  = ST_FORCED;
                end else begin
                    cnt_s = cnt_r - DLY_ONE;
                end
            end
            ST_FORCED: begin
                if (accept_s && cmd_op_i) begin
                    val_s = cmd_value_i;
                    if (dly_zero_s) begin
                        data_s = cmd_value_i;
                        done_s = 1'b1;
                    end else begin
                        cnt_s   = cmd_delay_i - DLY_ONE;
                        state_s = ST_WAIT;
                    end
                end else if (accept_s) begin
                    if (dly_zero_s) begin
                        data_s   = base_i;
                        forced_s = 1'b0;
                        done_s   = 1'b1;
                        state_s  = ST_IDLE;
                    end else begin
                        cnt_s   = cmd_delay_i - DLY_ONE;
                        state_s = ST_RWAIT;
                    end
                end else begin
                    data_s = data_r;
                end
            end
            ST_RWAIT: begin
                if (cnt_r == {DLY_W{1'b0}}) begin
                    data_s   = base_i;
                    forced_s = 1'b0;
                    done_s   = 1'b1;
                    state_s  = ST_IDLE;
                end else begin
                    cnt_s = cnt_r - DLY_ONE;
                end
            end
            default: begin
                data_s   = base_i;
                forced_s = 1'b0;
                state_s  = ST_IDLE;
            end
        endcase
    end

    // Saturating count of edges seen with the override applied.
    always_comb begin
        if (forced_r && (fcnt_r != CNT_MAX)) begin
            fcnt_s = fcnt_r + CNT_ONE;
        end else begin
            fcnt_s = fcnt_r;
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r  <= ST_IDLE;
            cnt_r    <= {DLY_W{1'b0}};
            val_r    <= {WIDTH{1'b0}};
            data_r   <= {WIDTH{1'b0}};
            forced_r <= 1'b0;
            done_r   <= 1'b0;
            err_r    <= 1'b0;
            fcnt_r   <= {CNT_W{1'b0}};
        end else begin
            state_r  <= state_s;
            cnt_r    <= cnt_s;
            val_r    <= val_s;
            data_r   <= data_s;
            forced_r <= forced_s;
            done_r   <= done_s;
            err_r    <= err_s;
            fcnt_r   <= fcnt_s;
        end
    end

    assign cmd_ready_o     = ready_s;
    assign data_o          = data_r;
    assign forced_o        = forced_r;
    assign done_o          = done_r;
    assign err_o           = err_r;
    assign forced_cycles_o = fcnt_r;

endmodule

// File: tb/tb_force_override_stage.sv
// Directed bench for force_override_stage; a second instance with a 2-bit
// forced-cycle counter shares the stimulus to exercise saturation.
module tb_force_override_stage;

    logic        clk;
    logic        rst_n;
    logic [7:0]  base_i;
    logic        cmd_valid_i;
    logic        cmd_op_i;
    logic [7:0]  cmd_value_i;
    logic [7:0]  cmd_delay_i;

    logic        cmd_ready_o, forced_o, done_o, err_o;
    logic [7:0]  data_o;
    logic [15:0] forced_cycles_o;

    logic        s_ready, s_forced, s_done, s_err;
    logic [7:0]  s_data;
    logic [1:0]  s_fcnt;

    int checks_r;
    int failures_r;

    force_override_stage #(.WIDTH(8), .DLY_W(8), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .base_i(base_i),
        .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
        .cmd_op_i(cmd_op_i), .cmd_value_i(cmd_value_i), .cmd_delay_i(cmd_delay_i),
        .data_o(data_o), .forced_o(forced_o), .done_o(done_o), .err_o(err_o),
        .forced_cycles_o(forced_cycles_o)
    );

    force_override_stage #(.WIDTH(8), .DLY_W(8), .CNT_W(2)) dut_sat (
        .clk(clk), .rst_n(rst_n), .base_i(base_i),
        .cmd_valid_i(cmd_valid_i), .cmd_ready_o(s_ready),
        .cmd_op_i(cmd_op_i), .cmd_value_i(cmd_value_i), .cmd_delay_i(cmd_delay_i),
        .data_o(s_data), .forced_o(s_forced), .done_o(s_done), .err_o(s_err),
        .forced_cycles_o(s_fcnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks_r++;
        if (act !== exp) begin
            failures_r++;
            $display("FAIL %s actual=%0h expected=%0h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic cmd(input logic op, input logic [7:0] val, input logic [7:0] dly);
        cmd_valid_i = 1'b1;
        cmd_op_i    = op;
        cmd_value_i = val;
        cmd_delay_i = dly;
        step();
        cmd_valid_i = 1'b0;
    endtask

    initial begin
        checks_r    = 0;
        failures_r  = 0;
        rst_n       = 1'b0;
        base_i      = 8'h00;
        cmd_valid_i = 1'b0;
        cmd_op_i    = 1'b0;
        cmd_value_i = 8'h00;
        cmd_delay_i = 8'h00;
        repeat (2) step();
        check("rst_data", 32'(data_o), 32'h00);
        check("rst_forced", 32'(forced_o), 32'h0);
        check("rst_done", 32'(done_o), 32'h0);
        check("rst_err", 32'(err_o), 32'h0);
        check("rst_fcnt", 32'(forced_cycles_o), 32'h0);
        check("rst_ready", 32'(cmd_ready_o), 32'h0);
        rst_n = 1'b1;
        #1;
        check("ready_after_rst", 32'(cmd_ready_o), 32'h1);

        // 1: baseline pass-through
        base_i = 8'h5A;
        for (int i = 0; i < 3; i++) begin
            step();
            check("t1_data", 32'(data_o), 32'h5A);
            check("t1_forced", 32'(forced_o), 32'h0);
            check("t1_fcnt", 32'(forced_cycles_o), 32'h0);
        end
        base_i = 8'hA5;
        #1;
        check("t1_latency_hold", 32'(data_o), 32'h5A);
        step();
        check("t1_latency_new", 32'(data_o), 32'hA5);

        // 2: immediate force, base ignored, immediate release after 5 forced edges
        cmd(1'b1, 8'hC3, 8'd0);
        check("t2_data", 32'(data_o), 32'hC3);
        check("t2_forced", 32'(forced_o), 32'h1);
        check("t2_done", 32'(done_o), 32'h1);
        base_i = 8'h77;
        step();
        check("t2_hold", 32'(data_o), 32'hC3);
        check("t2_done_pulse", 32'(done_o), 32'h0);
        base_i = 8'h88;
        repeat (3) step();
        check("t2_hold2", 32'(data_o), 32'hC3);
        base_i = 8'h9E;
        cmd(1'b0, 8'h00, 8'd0);
        check("t2_rel_data", 32'(data_o), 32'h9E);
        check("t2_rel_forced", 32'(forced_o), 32'h0);
        check("t2_rel_done", 32'(done_o), 32'h1);
        check("t2_fcnt", 32'(forced_cycles_o), 32'd5);
        check("t2_fcnt_sat", 32'(s_fcnt), 32'd3);
        base_i = 8'h9F;
        step();
        check("t2_track", 32'(data_o), 32'h9F);
        check("t2_done_clr", 32'(done_o), 32'h0);

        // 3: delayed force D=3
        base_i = 8'h20;
        cmd(1'b1, 8'h11, 8'd3);
        check("t3_ready_e0", 32'(cmd_ready_o), 32'h0);
        check("t3_data_e0", 32'(data_o), 32'h20);
        check("t3_forced_e0", 32'(forced_o), 32'h0);
        check("t3_done_e0", 32'(done_o), 32'h0);
        base_i = 8'h21;
        step();
        check("t3_ready_e1", 32'(cmd_ready_o), 32'h0);
        check("t3_data_e1", 32'(data_o), 32'h21);
        base_i = 8'h22;
        step();
        check("t3_ready_e2", 32'(cmd_ready_o), 32'h0);
        check("t3_data_e2", 32'(data_o), 32'h22);
        base_i = 8'h23;
        step();
        check("t3_data_apply", 32'(data_o), 32'h11);
        check("t3_done_apply", 32'(done_o), 32'h1);
        check("t3_forced_apply", 32'(forced_o), 32'h1);
        check("t3_ready_apply", 32'(cmd_ready_o), 32'h1);
        cmd(1'b0, 8'h00, 8'd0);
        check("t3_rel_forced", 32'(forced_o), 32'h0);
        check("t3_rel_data", 32'(data_o), 32'h23);
        check("t3_fcnt", 32'(forced_cycles_o), 32'd6);

        // 4: release while idle sets sticky error
        cmd(1'b0, 8'h00, 8'd0);
        check("t4_err", 32'(err_o), 32'h1);
        check("t4_no_done", 32'(done_o), 32'h0);
        check("t4_data", 32'(data_o), 32'h23);
        base_i = 8'h40;
        cmd(1'b1, 8'hAA, 8'd0);
        check("t4_force_done", 32'(done_o), 32'h1);
        check("t4_force_data", 32'(data_o), 32'hAA);
        check("t4_err_sticky1", 32'(err_o), 32'h1);
        base_i = 8'h41;
        cmd(1'b0, 8'h00, 8'd1);
        check("t4_rwait_ready", 32'(cmd_ready_o), 32'h0);
        check("t4_rwait_forced", 32'(forced_o), 32'h1);
        check("t4_rwait_data", 32'(data_o), 32'hAA);
        check("t4_rwait_done", 32'(done_o), 32'h0);
        step();
        check("t4_rel_forced", 32'(forced_o), 32'h0);
        check("t4_rel_done", 32'(done_o), 32'h1);
        check("t4_rel_data", 32'(data_o), 32'h41);
        check("t4_err_sticky2", 32'(err_o), 32'h1);
        check("t4_fcnt", 32'(forced_cycles_o), 32'd8);

        // 5: reset in the middle of a pending force
        base_i = 8'h50;
        cmd(1'b1, 8'hFF, 8'd4);
        step();
        step();
        #2;
        rst_n = 1'b0;
        #1;
        check("t5_async_data", 32'(data_o), 32'h00);
        check("t5_async_forced", 32'(forced_o), 32'h0);
        check("t5_async_ready", 32'(cmd_ready_o), 32'h0);
        check("t5_async_err", 32'(err_o), 32'h0);
        check("t5_async_fcnt", 32'(forced_cycles_o), 32'h0);
        step();
        check("t5_rst_done", 32'(done_o), 32'h0);
        rst_n = 1'b1;
        #1;
        check("t5_ready", 32'(cmd_ready_o), 32'h1);
        for (int i = 0; i < 5; i++) begin
            step();
            check("t5_no_done", 32'(done_o), 32'h0);
            check("t5_no_forced", 32'(forced_o), 32'h0);
        end
        check("t5_data", 32'(data_o), 32'h50);

        // 6: re-force while forced, plus counter saturation
        base_i = 8'h60;
        cmd(1'b1, 8'h22, 8'd0);
        check("t6_data22", 32'(data_o), 32'h22);
        cmd(1'b1, 8'h33, 8'd2);
        check("t6_hold_e0", 32'(data_o), 32'h22);
        check("t6_ready_e0", 32'(cmd_ready_o), 32'h0);
        check("t6_forced_e0", 32'(forced_o), 32'h1);
        check("t6_done_e0", 32'(done_o), 32'h0);
        step();
        check("t6_hold_e1", 32'(data_o), 32'h22);
        check("t6_forced_e1", 32'(forced_o), 32'h1);
        step();
        check("t6_data33", 32'(data_o), 32'h33);
        check("t6_done", 32'(done_o), 32'h1);
        check("t6_forced_e2", 32'(forced_o), 32'h1);
        check("t6_fcnt", 32'(forced_cycles_o), 32'd3);
        check("t6_fcnt_sat", 32'(s_fcnt), 32'd3);
        step();
        check("t6_fcnt_inc", 32'(forced_cycles_o), 32'd4);
        check("t6_fcnt_sat_hold", 32'(s_fcnt), 32'd3);
        check("t6_done_clr", 32'(done_o), 32'h0);

        // Back-to-back zero-delay commands give consecutive done pulses
        cmd(1'b0, 8'h00, 8'd0);
        check("b2b_done1", 32'(done_o), 32'h1);
        check("b2b_forced1", 32'(forced_o), 32'h0);
        cmd(1'b1, 8'h5C, 8'd0);
        check("b2b_done2", 32'(done_o), 32'h1);
        check("b2b_data2", 32'(data_o), 32'h5C);
        cmd(1'b0, 8'h00, 8'd0);
        check("b2b_done3", 32'(done_o), 32'h1);
        check("b2b_data3", 32'(data_o), 32'h60);
        check("b2b_fcnt", 32'(forced_cycles_o), 32'd6);

        $display("TB_RESULT checks=%0d failures=%0d", checks_r, failures_r);
        $finish;
    end

endmodule
